c5315_reg_alu: RTL and testbench



---
 rtl/c5315_pkg.sv | 58 +++++
 rtl/c5315_alu_slice.sv | 62 ++++++
 rtl/c5315_reg_alu.sv | 70 +++++++
 tb/tb_c5315_reg_alu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/c5315_pkg.sv
// Shared definitions for the c5315 registered dual ALU block:
// widths, op encoding, field offsets and the per-slice result record.
package c5315_pkg;

    localparam int DW    = 9;
    localparam int IN_W  = 178;
    localparam int OUT_W = 123;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_NAND  = 4'd6,
        OP_XNOR  = 4'd7,
        OP_PASSA = 4'd8,
        OP_PASSB = 4'd9,
        OP_NOTA  = 4'd10,
        OP_INC   = 4'd11,
        OP_DEC   = 4'd12,
        OP_SHL   = 4'd13,
        OP_SHR   = 4'd14,
        OP_ZERO  = 4'd15
    } op_e;

    // Input field LSB offsets
    localparam int A0_LSB    = 0;
    localparam int B0_LSB    = 9;
    localparam int A1_LSB    = 18;
    localparam int B1_LSB    = 27;
    localparam int OP0_LSB   = 36;
    localparam int OP1_LSB   = 40;
    localparam int CIN0_LSB  = 44;
    localparam int CIN1_LSB  = 45;
    localparam int RSVD_LSB  = 46;

    // Output field LSB offsets
    localparam int RES0_LSB  = 0;
    localparam int RES1_LSB  = 14;
    localparam int XOR_LSB   = 28;
    localparam int EQ_LSB    = 37;
    localparam int ZPAD_LSB  = 38;

    // Slice record, packed as {P,V,N,Z,C,R} with R in the LSBs (14 bits)
    typedef struct packed {
        logic          p;
        logic          v;
        logic          n;
        logic          z;
        logic          c;
        logic [DW-1:0] r;
    } slice_res_t;

    localparam int RES_W = $bits(slice_res_t);

endpackage

// File: rtl/c5315_alu_slice.sv
// One combinational 9-bit ALU slice: (A,B,OP,CIN) -> {P,V,N,Z,C,R}.
import c5315_pkg::*;

module c5315_alu_slice (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  op_e           op,
    input  logic          cin,
    output slice_res_t    res
);

    logic [DW-1:0] operand;
    logic          carry_in;
    logic          arith;
    logic [DW:0]   sum;
    logic [DW-1:0] r;
    logic          c;

    // Shared adder for ADD/SUB/INC/DEC; logic, pass and shift ops bypass it
    always_comb begin
        operand  = '0;
        carry_in = 1'b0;
        arith    = 1'b0;
        r        = '0;
        c        = 1'b0;
        case (op)
            OP_ADD:   begin operand = b;        carry_in = cin;  arith = 1'b1; end
            OP_SUB:   begin operand = ~b;       carry_in = cin;  arith = 1'b1; end
            OP_INC:   begin operand = 9'h001;   carry_in = 1'b0; arith = 1'b1; end
            OP_DEC:   begin operand = 9'h1FF;   carry_in = 1'b0; arith = 1'b1; end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_NAND:  r = ~(a & b);
            OP_XNOR:  r = ~(a ^ b);
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            OP_NOTA:  r = ~a;
            OP_SHL:   begin r = {a[DW-2:0], 1'b0}; c = a[DW-1]; end
            OP_SHR:   begin r = {1'b0, a[DW-1:1]}; c = a[0];    end
            OP_ZERO:  r = '0;
            default:  r = '0;
        endcase
        sum = {1'b0, a} + {1'b0, operand} + {{DW{1'b0}}, carry_in};
        if (arith) begin
            r = sum[DW-1:0];
            c = sum[DW];
        end
    end

    // Flags derived from the selected result; overflow only meaningful for adder ops
    always_comb begin
        res.r = r;
        res.c = c;
        res.z = (r == '0);
        res.n = r[DW-1];
        res.p = ^r;
        res.v = arith && (a[DW-1] == operand[DW-1]) && (sum[DW-1] != a[DW-1]);
    end

endmodule

// File: rtl/c5315_reg_alu.sv
// Registered dual 9-bit ALU: unpacks the stimulus vector, runs two slices,
// forms the cross-slice XOR/compare field and registers the whole result.
import c5315_pkg::*;

module c5315_reg_alu (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    logic [DW-1:0] a0, b0, a1, b1;
    logic [3:0]    op0_raw, op1_raw;
    logic          cin0, cin1;
    slice_res_t    res0, res1;
    logic [DW-1:0] cross_xor;
    logic          cross_eq;
    logic [OUT_W-1:0] next_out;
    logic          unused_reserved;

    assign a0      = in[A0_LSB   +: DW];
    assign b0      = in[B0_LSB   +: DW];
    assign a1      = in[A1_LSB   +: DW];
    assign b1      = in[B1_LSB   +: DW];
    assign op0_raw = in[OP0_LSB  +: 4];
    assign op1_raw = in[OP1_LSB  +: 4];
    assign cin0    = in[CIN0_LSB];
    assign cin1    = in[CIN1_LSB];

    // Reserved stimulus bits are deliberately ignored
    assign unused_reserved = ^in[IN_W-1:RSVD_LSB];

    c5315_alu_slice u_slice0 (
        .a   (a0),
        .b   (b0),
        .op  (op_e'(op0_raw)),
        .cin (cin0),
        .res (res0)
    );

    c5315_alu_slice u_slice1 (
        .a   (a1),
        .b   (b1),
        .op  (op_e'(op1_raw)),
        .cin (cin1),
        .res (res1)
    );

    assign cross_xor = res0.r ^ res1.r;
    assign cross_eq  = (res0.r == res1.r);

    // Assemble the result vector; everything above the compare bit is zero
    always_comb begin
        next_out = '0;
        next_out[RES0_LSB +: RES_W] = res0;
        next_out[RES1_LSB +: RES_W] = res1;
        next_out[XOR_LSB  +: DW]    = cross_xor;
        next_out[EQ_LSB]            = cross_eq;
    end

    // Single output register; async reset clears it and drops any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= next_out;
        end
    end

endmodule

// File: tb/tb_c5315_reg_alu.sv
// Self-checking bench for c5315_reg_alu: directed cases plus random vectors
// compared against an integer-arithmetic reference model.
module tb_c5315_reg_alu;

    logic         clk;
    logic         rst;
    logic [177:0] in;
    logic [122:0] out;

    int assertCount = 0;
    int failCount   = 0;

    c5315_reg_alu dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference for one slice, using plain integer arithmetic and signed ranges
    function automatic logic [13:0] refSlice(int a, int b, int op, int cin);
        int r, c, v, sb, ci, total, sa, ssb, s;
        logic [8:0] rr;
        logic p, z, n;
        bit arith;
        r = 0; c = 0; v = 0; sb = 0; ci = 0; arith = 0;
        case (op)
            0:  begin sb = b;       ci = cin; arith = 1; end
            1:  begin sb = 511 - b; ci = cin; arith = 1; end
            11: begin sb = 1;       ci = 0;   arith = 1; end
            12: begin sb = 511;     ci = 0;   arith = 1; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 511 - (a | b);
            6:  r = 511 - (a & b);
            7:  r = 511 - (a ^ b);
            8:  r = a;
            9:  r = b;
            10: r = 511 - a;
            13: begin r = (a * 2) % 512; c = a / 256; end
            14: begin r = a / 2;         c = a % 2;   end
            default: r = 0;
        endcase
        if (arith) begin
            total = a + sb + ci;
            r = total % 512;
            c = (total >= 512) ? 1 : 0;
            sa  = (a  >= 256) ? a  - 512 : a;
            ssb = (sb >= 256) ? sb - 512 : sb;
            s = sa + ssb + ci;
            v = (s > 255 || s < -256) ? 1 : 0;
        end
        rr = r[8:0];
        z = (r == 0);
        n = (r >= 256);
        p = $countones(rr) % 2 == 1;
        return {p, v[0], n, z, c[0], rr};
    endfunction

    // Reference for the whole output vector given one stimulus vector
    function automatic logic [122:0] refOut(logic [177:0] v);
        logic [13:0]  s0, s1;
        logic [122:0] o;
        s0 = refSlice(int'(v[8:0]), int'(v[17:9]), int'(v[39:36]), int'(v[44]));
        s1 = refSlice(int'(v[26:18]), int'(v[35:27]), int'(v[43:40]), int'(v[45]));
        o = '0;
        o[13:0]  = s0;
        o[27:14] = s1;
        o[36:28] = s0[8:0] ^ s1[8:0];
        o[37]    = (s0[8:0] == s1[8:0]);
        return o;
    endfunction

    function automatic logic [177:0] mkVec(logic [8:0] a0, logic [8:0] b0,
                                           logic [8:0] a1, logic [8:0] b1,
                                           logic [3:0] op0, logic [3:0] op1,
                                           logic cin0, logic cin1);
        logic [177:0] v;
        v = '0;
        v[8:0] = a0; v[17:9] = b0; v[26:18] = a1; v[35:27] = b1;
        v[39:36] = op0; v[43:40] = op1; v[44] = cin0; v[45] = cin1;
        return v;
    endfunction

    function automatic logic [177:0] randVec();
        logic [191:0] w;
        for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
        return w[177:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [122:0] actual,
                               input logic [122:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive a vector away from the active edge, then wait past the next edge
    task automatic applyStimulus(input logic [177:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1;
    endtask

    logic [177:0] vec, prevVec;

    initial begin
        // Async reset with no clock edge yet
        rst = 1'b1;
        in  = '1;
        #1;
        checkOutput("reset_no_edge", out, '0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", out, refOut(in));

        // ADD overflow into sign bit: R=100 C=0 V=1 N=1 Z=0 P=1
        vec = mkVec(9'h0FF, 9'h001, 9'h000, 9'h000, 4'd0, 4'd15, 1'b0, 1'b0);
        applyStimulus(vec);
        checkOutput("add_ovf_rec", {109'd0, out[13:0]}, {109'd0, 14'b11100_100000000});
        checkOutput("add_ovf_all", out, refOut(vec));

        // ADD wrap to zero: R=0 C=1 Z=1 V=0
        vec = mkVec(9'h1FF, 9'h001, 9'h000, 9'h000, 4'd0, 4'd15, 1'b0, 1'b0);
        applyStimulus(vec);
        checkOutput("add_wrap_rec", {109'd0, out[13:0]}, {109'd0, 14'b00011_000000000});

        // SUB equal operands: R=0 C=1 Z=1
        vec = mkVec(9'h000, 9'h000, 9'd5, 9'd5, 4'd15, 4'd1, 1'b0, 1'b1);
        applyStimulus(vec);
        checkOutput("sub_eq_rec", {109'd0, out[27:14]}, {109'd0, 14'b00011_000000000});

        // SUB negative result: R=1FE C=0 N=1 P=0
        vec = mkVec(9'h000, 9'h000, 9'd3, 9'd5, 4'd15, 4'd1, 1'b0, 1'b1);
        applyStimulus(vec);
        checkOutput("sub_neg_rec", {109'd0, out[27:14]}, {109'd0, 14'b00100_111111110});
        checkOutput("sub_neg_all", out, refOut(vec));

        // Op sweep on both slices with A=155 B=0F0
        for (int k = 0; k < 16; k++) begin
            vec = mkVec(9'h155, 9'h0F0, 9'h155, 9'h0F0, k[3:0], k[3:0], k[0], ~k[0]);
            applyStimulus(vec);
            checkOutput($sformatf("sweep_op%0d", k), out, refOut(vec));
            if (k == 13 || k == 14)
                checkOutput($sformatf("sweep_shift%0d_rc", k),
                            {113'd0, out[9:0]}, {113'd0, 10'b1_010101010});
            if (k == 10)
                checkOutput("sweep_nota_r", {114'd0, out[8:0]}, {114'd0, 9'h0AA});
        end

        // Cross fields: equal results
        vec = mkVec(9'h007, 9'h000, 9'h007, 9'h000, 4'd8, 4'd8, 1'b0, 1'b0);
        applyStimulus(vec);
        checkOutput("cross_eq", {113'd0, out[37:28]}, {113'd0, 10'b1_000000000});

        // Cross fields: differing results
        vec = mkVec(9'h007, 9'h000, 9'h003, 9'h000, 4'd8, 4'd8, 1'b0, 1'b0);
        applyStimulus(vec);
        checkOutput("cross_ne", {113'd0, out[37:28]}, {113'd0, 10'b0_000000100});

        // Mid-stream async reset clears output before any edge
        vec = randVec();
        applyStimulus(vec);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_mid", out, '0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", out, '0);
        @(negedge clk);
        rst = 1'b0;
        in = randVec();
        @(posedge clk);
        #1;
        checkOutput("reset_mid_release", out, refOut(in));

        // Random vectors with random reserved bits; check registered behaviour
        prevVec = in;
        for (int i = 0; i < 10000; i++) begin
            vec = randVec();
            @(negedge clk);
            in = vec;
            #1;
            checkOutput("rand_hold", out, refOut(prevVec));
            @(posedge clk);
            #1;
            checkOutput("rand_out", out, refOut(vec));
            checkOutput("rand_pad_zero", {38'd0, out[122:38]}, '0);
            prevVec = vec;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
